// File: rtl/comparador_serial_der_izq.sv
// Bit-serial unsigned magnitude comparator, scanning LSB first.
// Produces the same flag pair as the combinational left-to-right chain:
// f_out = A>B, g_out = A<B, both low when the operands are equal.
// Because bits arrive in rising significance, any difference seen later
// simply overwrites the accumulated flags.

module comparador_serial_der_izq #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             f_out,
  output logic             g_out
);

  // One extra counter bit so the count never wraps, even at WIDTH=32.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [CW-1:0]    cnt_r;
  logic             f_acc_r;
  logic             g_acc_r;
  logic             f_next_s;
  logic             g_next_s;

  // Flag update for one bit position: a differing bit decides the result
  // outright (it is more significant than anything seen so far), an equal
  // bit leaves the previous decision untouched. Returns {f, g}.
  function automatic logic [1:0] acc_update(input logic a, input logic b,
                                             input logic f, input logic g);
    logic [1:0] res;
    if (a != b) begin
      res = {a & ~b, ~a & b};
    end else begin
      res = {f, g};
    end
    return res;
  endfunction

  // Next accumulator value from the bit currently at the bottom of the shifters.
  always_comb begin
    f_next_s = 1'b0;
    g_next_s = 1'b0;
    {f_next_s, g_next_s} = acc_update(sa_r[0], sb_r[0], f_acc_r, g_acc_r);
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      cnt_r   <= '0;
      f_acc_r <= 1'b0;
      g_acc_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f_out   <= 1'b0;
      g_out   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_r    <= A;
            sb_r    <= B;
            cnt_r   <= '0;
            f_acc_r <= 1'b0;
            g_acc_r <= 1'b0;
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          f_acc_r <= f_next_s;
          g_acc_r <= g_next_s;
          sa_r    <= sa_r >> 1'b1;
          sb_r    <= sb_r >> 1'b1;
          cnt_r   <= cnt_r + CNT_ONE;
          busy    <= 1'b1;
          // The MSB is processed on this edge; publish the final flags now
          // so they are valid during the done cycle.
          if (cnt_r == CNT_LAST) begin
            f_out   <= f_next_s;
            g_out   <= g_next_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            done    <= 1'b0;
            state_r <= SHIFT;
          end
        end
        DONE: begin
          // start is deliberately ignored here; a new request needs IDLE.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Directed bench for the LSB-first serial comparator at WIDTH 3, 8 and 1.

module tb_comparador_serial_der_izq;

  logic       clk;
  logic       rst;
  logic       start3, start8, start1;
  logic [2:0] a3, b3;
  logic [7:0] a8, b8;
  logic       a1, b1;
  logic       busy3, done3, f3, g3;
  logic       busy8, done8, f8, g8;
  logic       busy1, done1, f1, g1;

  int tests;
  int fails;

  comparador_serial_der_izq #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3),
    .busy(busy3), .done(done3), .f_out(f3), .g_out(g3)
  );

  comparador_serial_der_izq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .f_out(f8), .g_out(g8)
  );

  comparador_serial_der_izq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .f_out(f1), .g_out(g1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed {busy, done, f_out, g_out} of the instance with width w.
  function automatic logic [3:0] obs(input int w);
    if (w == 8) return {busy8, done8, f8, g8};
    else if (w == 1) return {busy1, done1, f1, g1};
    else return {busy3, done3, f3, g3};
  endfunction

  // One full comparison on instance w with latency, result and pulse checks.
  task automatic run_cmp(input int w, input logic [7:0] a, input logic [7:0] b,
                         input string name);
    logic [3:0] o;
    int lat;
    logic ef, eg;
    ef = (a > b);
    eg = (a < b);
    @(negedge clk);
    start3 = (w == 3); start8 = (w == 8); start1 = (w == 1);
    a3 = a[2:0]; b3 = b[2:0];
    a8 = a;      b8 = b;
    a1 = a[0];   b1 = b[0];
    @(negedge clk);
    start3 = 1'b0; start8 = 1'b0; start1 = 1'b0;
    o = obs(w);
    tests++;
    if (o[3] !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, o[3]);
    end
    lat = 0;
    while (obs(w)[2] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    o = obs(w);
    tests++;
    if (lat !== w) begin
      fails++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, w);
    end
    tests++;
    if (o[1:0] !== {ef, eg}) begin
      fails++;
      $display("FAIL %s result a=%0d b=%0d: got f=%b g=%b expected f=%b g=%b",
               name, a, b, o[1], o[0], ef, eg);
    end
    tests++;
    if ((o[1] & o[0]) !== 1'b0) begin
      fails++;
      $display("FAIL %s both_flags: got f=%b g=%b expected not both 1", name, o[1], o[0]);
    end
    @(negedge clk);
    o = obs(w);
    tests++;
    if (o !== {2'b00, ef, eg}) begin
      fails++;
      $display("FAIL %s after_done: got %b expected %b", name, o, {2'b00, ef, eg});
    end
  endtask

  task automatic test_reset;
    logic [3:0] o;
    rst = 1'b1;
    start3 = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a3 = 3'd0; b3 = 3'd0; a8 = 8'd0; b8 = 8'd0; a1 = 1'b0; b1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      o = obs(3);
      tests++;
      if (o !== 4'b0000 || obs(8) !== 4'b0000 || obs(1) !== 4'b0000) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %b/%b/%b expected 0000", i, o, obs(8), obs(1));
      end
    end
  endtask

  task automatic test_basic;
    run_cmp(3, 8'd5, 8'd3, "a5_b3");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (obs(3) !== 4'b0010) begin
        fails++;
        $display("FAIL hold_a5_b3 cycle %0d: got %b expected 0010", i, obs(3));
      end
    end
  endtask

  task automatic test_directed;
    run_cmp(3, 8'd2, 8'd6, "a2_b6");
    run_cmp(3, 8'd4, 8'd4, "a4_b4");
    run_cmp(3, 8'd3, 8'd4, "a3_b4");
    run_cmp(3, 8'd6, 8'd7, "a6_b7");
  endtask

  // start held high: one result every 5 cycles, mid-run A change ignored.
  task automatic test_back_to_back;
    logic [3:0] o;
    logic exp_done, exp_busy;
    @(negedge clk);
    a3 = 3'd1; b3 = 3'd0; start3 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      o = obs(3);
      exp_done = ((c % 5) == 4);
      exp_busy = ((c % 5) != 0);
      tests++;
      if (o[2] !== exp_done || o[3] !== exp_busy) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got busy=%b done=%b expected busy=%b done=%b",
                 c, o[3], o[2], exp_busy, exp_done);
      end
      if (exp_done) begin
        tests++;
        if (o[1:0] !== 2'b10) begin
          fails++;
          $display("FAIL back_to_back_result cycle %0d: got %b expected 10", c, o[1:0]);
        end
      end
      if (c == 1) a3 = 3'd0;
      if (c == 4) a3 = 3'd1;
    end
    start3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [3:0] o;
    @(negedge clk);
    a3 = 3'd7; b3 = 3'd0; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    rst = 1'b1;
    #1;
    o = obs(3);
    tests++;
    if (o !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_immediate: got %b expected 0000", o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (obs(3) !== 4'b0000) begin
        fails++;
        $display("FAIL reset_mid_no_done cycle %0d: got %b expected 0000", i, obs(3));
      end
    end
    run_cmp(3, 8'd0, 8'd7, "after_reset_a0_b7");
  endtask

  task automatic test_exhaustive3;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_cmp(3, 8'(a), 8'(b), "exh3");
      end
    end
  endtask

  task automatic test_width8;
    run_cmp(8, 8'd255, 8'd0, "w8_max_zero");
    run_cmp(8, 8'd0, 8'd255, "w8_zero_max");
    run_cmp(8, 8'd128, 8'd127, "w8_msb_decides");
    run_cmp(8, 8'd1, 8'd2, "w8_low");
    run_cmp(8, 8'd170, 8'd170, "w8_equal");
    for (int i = 0; i < 20; i++) begin
      run_cmp(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "w8_rand");
    end
  endtask

  task automatic test_width1;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        run_cmp(1, 8'(a), 8'(b), "w1");
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive3();
    test_width8();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
